sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 640, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 480, framebuffer height in pixels.
REQ-003 SHALL have parameter CLEAR_VALUE, default 16'h0000, word written by clear sweep.
REQ-004 SHALL have ports: clk50  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: vid_req  in  1 / vid_addr  in  20 / vid_ack  out  1 / vid_rdata  out  16 / vid_rvalid  out  1; video scanout read port.
REQ-007 SHALL have ports: wr_req  in  1 / wr_addr  in  20 / wr_data  in  16 / wr_be  in  2 (bit1 upper, bit0 lower byte) / wr_ack  out  1; draw engine write port.
REQ-008 SHALL have ports: clr_start  in  1  pulse starting clear / clr_busy  out  1 / clr_done  out  1  one-cycle pulse.
REQ-009 SHALL have ports: SRAM_ADDR  out  20 / SRAM_DQ  inout  16 / SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each, all active-low.

Function
REQ-010 SHALL implement states IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE; every access lasts exactly 2 cycles.
REQ-011 SHALL arbitrate only in IDLE, RD_CAP and WR_PULSE; winner's access starts the next cycle (back-to-back, no idle gap).
REQ-012 SHALL use fixed priority video > clear > draw; draw writes never granted while clr_busy=1.
REQ-013 SHALL register winner's address, data and byte enables at arbitration; they stay constant for the whole access.
REQ-014 SHALL pulse vid_ack / wr_ack high for exactly the first cycle of the granted access (RD / WR_SETUP); requester holds req and payload until it samples ack=1.
REQ-015 Read: RD and RD_CAP drive CE_N=0, OE_N=0, UB_N=LB_N=0, DQ high-Z; SRAM_DQ sampled at the rising edge ending RD_CAP.
REQ-016 Read latency: arbitration in cycle T -> vid_ack at T+1 -> vid_rvalid=1 for one cycle at T+3 with vid_rdata holding the sampled word; vid_rdata held until next read.
REQ-017 Write: WR_SETUP and WR_PULSE drive CE_N=0, OE_N=1, DQ=data, UB_N=~be[1], LB_N=~be[0]; WE_N=0 only in WR_PULSE.
REQ-018 SHALL release SRAM_DQ to high-Z in every state except WR_SETUP and WR_PULSE; CE_N=1, OE_N=1, WE_N=1, UB_N=LB_N=1 in IDLE.
REQ-019 Clear: clr_start with clr_busy=0 sets clr_busy and clear address 0; each clear grant writes CLEAR_VALUE with both bytes enabled, then increments address.
REQ-020 Clear SHALL finish after writing address FB_WIDTH*FB_HEIGHT-1 (307199 default): clr_busy falls and clr_done pulses in the cycle after that write's WR_PULSE.
REQ-021 clr_start while clr_busy=1 SHALL be ignored (no restart, address unchanged).
REQ-022 Pending wr_req during clear SHALL stay un-acked and be granted at the first arbitration after clr_busy falls, if no vid_req.
REQ-023 Simultaneous vid_req, active clear and wr_req SHALL grant video; next slot clear; draw waits.
REQ-024 With no requests, arbitration cycle SHALL transition to IDLE.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, CE_N/OE_N/WE_N/UB_N/LB_N=1, DQ high-Z, SRAM_ADDR=0, vid_ack=wr_ack=0, vid_rvalid=0, vid_rdata=0, clr_busy=0, clr_done=0, clear address 0.
REQ-026 Reset during access or clear SHALL abort it; no ack, rvalid or clr_done pulse for the aborted operation; normal operation from first clock edge after rst_n rises.

Structure
REQ-027 Package sram_pkg SHALL hold state encoding, FB_WIDTH/FB_HEIGHT defaults, FB_WORDS constant and 20-bit address width.
REQ-028 Clear address counter and terminal detect SHALL be sub-module sram_clear_gen; arbitration, FSM and pin drive stay in sram_arbiter.

Verification
REQ-029 Single read: vid_req, vid_addr=0x00100, SRAM model holds 0xBEEF -> vid_ack at T+1, vid_rvalid with vid_rdata=0xBEEF at T+3, OE_N low 2 cycles, WE_N stays 1.
REQ-030 Single write: wr_addr=0x12C00, wr_data=0x55AA, wr_be=2'b01 -> wr_ack at T+1, WE_N low one cycle, LB_N=0, UB_N=1, DQ driven 2 cycles then high-Z; model upper byte unchanged.
REQ-031 Contention: vid_req and wr_req both high from IDLE -> read granted first, write acked 2 cycles later, no gap cycle.
REQ-032 Full clear with FB_WIDTH=4, FB_HEIGHT=3, continuous wr_req -> 12 writes of CLEAR_VALUE to 0..11, clr_done one pulse, wr_ack only after clr_busy falls.
REQ-033 Clear with interleaved vid_req every 4 cycles -> reads served at priority, clear still completes all 307200 words with no skipped or repeated address.
REQ-034 rst_n low mid-WR_PULSE and mid-clear -> all pins to reset values asynchronously, no clr_done, fresh clr_start restarts at address 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter and its clear sweep generator.
package sram_pkg;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 16;
    localparam int FB_WIDTH_DEF = 640;
    localparam int FB_HEIGHT_DEF = 480;
    localparam int FB_WORDS     = FB_WIDTH_DEF * FB_HEIGHT_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_CAP,
        ST_WR_SETUP,
        ST_WR_PULSE
    } state_e;

    // States in which the next access may be chosen, keeping accesses back-to-back.
    function automatic logic is_arb_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_RD_CAP) || (s == ST_WR_PULSE);
    endfunction

endpackage

// File: rtl/sram_clear_gen.sv
// Clear sweep address counter: walks 0..WORDS-1, one address per clear grant.
module sram_clear_gen
    import sram_pkg::*;
#(
    parameter int WORDS = FB_WORDS
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              clr_start,
    input  logic              grant,
    input  logic              wr_end,
    output logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic              busy_q, busy_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        busy_d = busy_q;
        last_d = last_q;
        done_d = 1'b0;
        addr_d = addr_q;
        if (!busy_q) begin
            if (clr_start) begin
                busy_d = 1'b1;
                last_d = 1'b0;
                addr_d = '0;
            end
        end else begin
            // The final address is held; busy only drops once its write pulse has finished.
            if (grant) begin
                if (addr_q == LAST_ADDR) last_d = 1'b1;
                else                     addr_d = addr_q + 1'b1;
            end
            if (wr_end && last_q) begin
                busy_d = 1'b0;
                last_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
        end else begin
            busy_q <= busy_d;
            last_q <= last_d;
            done_q <= done_d;
            addr_q <= addr_d;
        end
    end

    assign clr_req  = busy_q & ~last_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;
    assign clr_addr = addr_q;

endmodule

// File: rtl/sram_arbiter.sv
// Async SRAM arbiter: video reads > clear sweep > draw writes, two-cycle accesses.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int          FB_WIDTH    = FB_WIDTH_DEF,
    parameter int          FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int WORDS = FB_WIDTH * FB_HEIGHT;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        be_q, be_d;
    logic              cur_clr_q, cur_clr_d;
    logic              vid_ack_q, vid_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d, dq_oe_q, dq_oe_d;

    logic              arb_ok, gnt_vid, gnt_clr, gnt_wr, wr_st;
    logic              clr_req, wr_end;
    logic [ADDR_W-1:0] clr_addr;

    sram_clear_gen #(.WORDS(WORDS)) u_clear_gen (
        .clk50    (clk50),
        .rst_n    (rst_n),
        .clr_start(clr_start),
        .grant    (gnt_clr),
        .wr_end   (wr_end),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_addr (clr_addr)
    );

    assign wr_end = (state_q == ST_WR_PULSE) && cur_clr_q;

    always_comb begin
        arb_ok  = is_arb_state(state_q);
        gnt_vid = arb_ok & vid_req;
        gnt_clr = arb_ok & ~vid_req & clr_req;
        gnt_wr  = arb_ok & ~vid_req & ~clr_req & ~clr_busy & wr_req;

        state_d = ST_IDLE;
        case (state_q)
            ST_RD:       state_d = ST_RD_CAP;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            default: begin
                if (gnt_vid)               state_d = ST_RD;
                else if (gnt_clr || gnt_wr) state_d = ST_WR_SETUP;
                else                        state_d = ST_IDLE;
            end
        endcase

        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        cur_clr_d = cur_clr_q;
        if (gnt_vid) begin
            addr_d    = vid_addr;
            be_d      = 2'b11;
            cur_clr_d = 1'b0;
        end else if (gnt_clr) begin
            addr_d    = clr_addr;
            data_d    = CLEAR_VALUE;
            be_d      = 2'b11;
            cur_clr_d = 1'b1;
        end else if (gnt_wr) begin
            addr_d    = wr_addr;
            data_d    = wr_data;
            be_d      = wr_be;
            cur_clr_d = 1'b0;
        end

        vid_ack_d = gnt_vid;
        wr_ack_d  = gnt_wr;
        rvalid_d  = (state_q == ST_RD_CAP);
        rdata_d   = (state_q == ST_RD_CAP) ? SRAM_DQ : rdata_q;

        // Pin flops are loaded from the next state so they line up with state_q.
        wr_st   = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE);
        ce_n_d  = (state_d == ST_IDLE);
        oe_n_d  = !((state_d == ST_RD) || (state_d == ST_RD_CAP));
        we_n_d  = (state_d != ST_WR_PULSE);
        ub_n_d  = wr_st ? ~be_d[1] : (state_d == ST_IDLE);
        lb_n_d  = wr_st ? ~be_d[0] : (state_d == ST_IDLE);
        dq_oe_d = wr_st;
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            cur_clr_q <= 1'b0;
            vid_ack_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            cur_clr_q <= cur_clr_d;
            vid_ack_q <= vid_ack_d;
            wr_ack_q  <= wr_ack_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
            dq_oe_q   <= dq_oe_d;
        end
    end

    assign SRAM_DQ    = dq_oe_q ? data_q : 16'hzzzz;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;
    assign vid_ack    = vid_ack_q;
    assign wr_ack     = wr_ack_q;
    assign vid_rvalid = rvalid_q;
    assign vid_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small 4x3 framebuffer and a behavioural SRAM.
module tb_sram_arbiter;

    logic        clk50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [19:0] vid_addr = '0;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        vid_rvalid;
    logic        wr_req = 1'b0;
    logic [19:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        wr_ack;
    logic        clr_start = 1'b0;
    logic        clr_busy, clr_done;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] mem [0:1048575];
    logic [19:0] log_addr [$];
    logic [15:0] log_data [$];

    always #10 clk50 = ~clk50;

    sram_arbiter #(.FB_WIDTH(4), .FB_HEIGHT(3), .CLEAR_VALUE(16'hA5C3)) dut (
        .clk50(clk50), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // Undriven bus floats to all-ones so a released DQ is visible.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
    end

    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk50) begin
        if (!ce_n && !we_n) begin
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
            log_addr.push_back(sram_addr);
            log_data.push_back(sram_dq);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    initial begin
        int done_n, done_k, ack_k, rv_n, rv_bad;
        logic ack_busy;

        mem[20'h00100] = 16'hBEEF;
        mem[20'h12C00] = 16'h1234;
        mem[20'h00400] = 16'h0404;
        for (int i = 0; i < 12; i++) mem[i] = 16'h1000 + 16'(i);

        // reset values
        #25;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_ub_lb", {ub_n, lb_n}, 2'b11);
        chk("rst_addr", sram_addr, 0);
        chk("rst_acks", {vid_ack, wr_ack, vid_rvalid}, 3'b000);
        chk("rst_rdata", vid_rdata, 0);
        chk("rst_clr", {clr_busy, clr_done}, 2'b00);
        chk("rst_dq_z", sram_dq, 16'hFFFF);
        @(negedge clk50) rst_n = 1'b1;
        tick();

        // single read
        vid_req = 1'b1; vid_addr = 20'h00100;
        tick();
        chk("rd_ack", vid_ack, 1);
        chk("rd_oe1", {ce_n, oe_n, we_n}, 3'b001);
        vid_req = 1'b0;
        tick();
        chk("rd_oe2", {oe_n, we_n, vid_rvalid, vid_ack}, 4'b0100);
        tick();
        chk("rd_rvalid", vid_rvalid, 1);
        chk("rd_rdata", vid_rdata, 16'hBEEF);
        chk("rd_oe_off", {ce_n, oe_n, we_n}, 3'b111);
        tick();
        chk("rd_hold", {vid_rvalid, vid_rdata}, {1'b0, 16'hBEEF});

        // single write, lower byte only
        wr_req = 1'b1; wr_addr = 20'h12C00; wr_data = 16'h55AA; wr_be = 2'b01;
        tick();
        chk("wr_ack", wr_ack, 1);
        chk("wr_setup_pins", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b01110);
        chk("wr_setup_dq", sram_dq, 16'h55AA);
        chk("wr_setup_addr", sram_addr, 20'h12C00);
        wr_req = 1'b0;
        tick();
        chk("wr_pulse_pins", {ce_n, oe_n, we_n, ub_n, lb_n, wr_ack}, 6'b010100);
        chk("wr_pulse_dq", sram_dq, 16'h55AA);
        tick();
        chk("wr_end_we", {ce_n, we_n}, 2'b11);
        chk("wr_end_dq_z", sram_dq, 16'hFFFF);
        chk("wr_mem_byte", mem[20'h12C00], 16'h12AA);

        // contention: read first, write in the very next slot
        vid_req = 1'b1; vid_addr = 20'h00100;
        wr_req = 1'b1; wr_addr = 20'h00200; wr_data = 16'h1111; wr_be = 2'b11;
        tick();
        chk("cont_t1", {vid_ack, wr_ack}, 2'b10);
        vid_req = 1'b0;
        tick();
        chk("cont_t2", {vid_ack, wr_ack, oe_n}, 3'b000);
        tick();
        chk("cont_t3", {wr_ack, vid_rvalid, ce_n, oe_n, we_n}, 5'b11011);
        wr_req = 1'b0;
        tick();
        chk("cont_t4_we", we_n, 0);
        tick();
        chk("cont_mem", mem[20'h00200], 16'h1111);

        // full clear with a draw write held pending throughout
        log_addr.delete(); log_data.delete();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("clr_busy_set", clr_busy, 1);
        wr_req = 1'b1; wr_addr = 20'h00300; wr_data = 16'h7777; wr_be = 2'b11;
        done_n = 0; done_k = -1; ack_k = -1; ack_busy = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            clr_start = (k == 4);
            if (clr_done) begin done_n++; done_k = k; end
            if (wr_ack && ack_k < 0) begin ack_k = k; ack_busy = clr_busy; wr_req = 1'b0; end
            if (ack_k >= 0 && k > ack_k + 3) break;
        end
        clr_start = 1'b0; wr_req = 1'b0;
        chk("clr_ack_seen", ack_k >= 0, 1);
        chk("clr_done_cnt", done_n, 1);
        chk("clr_ack_after", ack_k, done_k + 1);
        chk("clr_ack_busy", ack_busy, 0);
        chk("clr_nwrites", log_addr.size(), 13);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("clr_addr%0d", i), log_addr[i], i);
            chk($sformatf("clr_data%0d", i), log_data[i], 16'hA5C3);
        end
        chk("clr_mem11", mem[11], 16'hA5C3);
        chk("clr_draw_addr", log_addr[12], 20'h00300);

        // clear with video reads every 4 cycles
        log_addr.delete(); log_data.delete();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        done_n = 0; done_k = -1; rv_n = 0; rv_bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (vid_ack) vid_req = 1'b0;
            if (vid_rvalid) begin rv_n++; if (vid_rdata !== 16'hBEEF) rv_bad++; end
            if (clr_done) begin done_n++; done_k = k; end
            if (done_k < 0 && (k % 4) == 0) begin vid_req = 1'b1; vid_addr = 20'h00100; end
            if (done_k >= 0 && k > done_k + 4) break;
        end
        vid_req = 1'b0;
        chk("ilv_done_cnt", done_n, 1);
        chk("ilv_nwrites", log_addr.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("ilv_addr%0d", i), log_addr[i], i);
        chk("ilv_reads", rv_n >= 3, 1);
        chk("ilv_rdata", rv_bad, 0);

        // reset in the middle of a write pulse
        wr_req = 1'b1; wr_addr = 20'h00400; wr_data = 16'h9999; wr_be = 2'b11;
        tick();
        wr_req = 1'b0;
        tick();
        chk("rstw_pulse", we_n, 0);
        #4 rst_n = 1'b0;
        #1;
        chk("rstw_pins", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
        chk("rstw_dq_z", sram_dq, 16'hFFFF);
        chk("rstw_addr", sram_addr, 0);
        @(negedge clk50) rst_n = 1'b1;
        tick();
        chk("rstw_mem", mem[20'h00400], 16'h0404);
        chk("rstw_ack", wr_ack, 0);

        // reset in the middle of a clear, then a fresh clear
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (5) tick();
        chk("rstc_busy", clr_busy, 1);
        #4 rst_n = 1'b0;
        #1;
        chk("rstc_busy_off", {clr_busy, ce_n}, 2'b01);
        repeat (2) @(posedge clk50);
        @(negedge clk50) rst_n = 1'b1;
        done_n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (clr_done) done_n++;
        end
        chk("rstc_no_done", {done_n[0], clr_busy}, 2'b00);
        log_addr.delete(); log_data.delete();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        done_n = 0;
        for (int k = 0; k < 60 && done_n == 0; k++) begin
            tick();
            if (clr_done) done_n++;
        end
        chk("rstc_restart_done", done_n, 1);
        chk("rstc_first_addr", log_addr[0], 0);
        chk("rstc_nwrites", log_addr.size(), 12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
